// File: rtl/duplex_transfer_scheduler.sv
// Flow-control and test sequencer between the okPipeIn/okPipeOut endpoints and the
// 32-bit loopback FIFO: gates pipe strobes into FIFO enables and runs flush/run/drain.
module duplex_transfer_scheduler #(
  parameter int DEPTH        = 1024,
  parameter int BLOCK_WORDS  = 256,
  parameter int FLUSH_CYCLES = 4,
  localparam int LW          = $clog2(DEPTH) + 1
) (
  input  logic          okClk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          stop,
  input  logic          clear,
  input  logic [31:0]   transfer_len,
  input  logic          pipe_in_write,
  input  logic          pipe_out_read,
  output logic          fifo_wr_en,
  output logic          fifo_rd_en,
  output logic          fifo_flush,
  output logic          pipe_in_ready,
  output logic          pipe_out_ready,
  output logic [LW-1:0] level,
  output logic [31:0]   words_in,
  output logic [31:0]   words_out,
  output logic [63:0]   clk_counts,
  output logic [2:0]    state,
  output logic          busy,
  output logic          done,
  output logic          aborted,
  output logic          overflow,
  output logic          underflow
);

  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FLUSH = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t          state_reg;
  logic [31:0]     len_reg;
  logic [LW-1:0]   level_reg;
  logic [31:0]     words_in_reg;
  logic [31:0]     words_out_reg;
  logic [63:0]     clk_counts_reg;
  logic [FCW-1:0]  flush_cnt_reg;
  logic            aborted_reg;
  logic            overflow_reg;
  logic            underflow_reg;

  logic            in_run;
  logic            in_xfer;
  logic            level_full;
  logic            level_empty;
  logic [31:0]     space_left;
  logic [31:0]     out_remain;
  logic [31:0]     out_need;

  assign in_run      = (state_reg == RUN);
  assign in_xfer     = (state_reg == RUN) || (state_reg == DRAIN);
  assign level_full  = (level_reg == LW'(DEPTH));
  assign level_empty = (level_reg == '0);

  // Enables are the only combinational paths: the FIFO must see them with the pipe strobe.
  assign fifo_wr_en = pipe_in_write && in_run && !level_full && (words_in_reg < len_reg);
  assign fifo_rd_en = pipe_out_read && in_xfer && !level_empty;

  assign space_left = 32'(DEPTH) - 32'(level_reg);
  assign out_remain = len_reg - words_out_reg;
  assign out_need   = (out_remain < 32'(BLOCK_WORDS)) ? out_remain : 32'(BLOCK_WORDS);

  // Flags decode flops only, so they track the registered level with no input path.
  assign pipe_in_ready  = in_run && (space_left >= 32'(BLOCK_WORDS)) && (len_reg != words_in_reg);
  assign pipe_out_ready = in_xfer && (32'(level_reg) >= out_need) && !level_empty;

  assign fifo_flush = (state_reg == FLUSH);
  assign busy       = (state_reg == FLUSH) || in_xfer;
  assign done       = (state_reg == DONE);
  assign state      = state_reg;
  assign level      = level_reg;
  assign words_in   = words_in_reg;
  assign words_out  = words_out_reg;
  assign clk_counts = clk_counts_reg;
  assign aborted    = aborted_reg;
  assign overflow   = overflow_reg;
  assign underflow  = underflow_reg;

  always_ff @(posedge okClk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      len_reg        <= '0;
      level_reg      <= '0;
      words_in_reg   <= '0;
      words_out_reg  <= '0;
      clk_counts_reg <= '0;
      flush_cnt_reg  <= '0;
      aborted_reg    <= 1'b0;
      overflow_reg   <= 1'b0;
      underflow_reg  <= 1'b0;
    end else if (clear) begin
      state_reg      <= IDLE;
      len_reg        <= '0;
      level_reg      <= '0;
      words_in_reg   <= '0;
      words_out_reg  <= '0;
      clk_counts_reg <= '0;
      flush_cnt_reg  <= '0;
      aborted_reg    <= 1'b0;
      overflow_reg   <= 1'b0;
      underflow_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            state_reg      <= FLUSH;
            len_reg        <= transfer_len;
            level_reg      <= '0;
            words_in_reg   <= '0;
            words_out_reg  <= '0;
            clk_counts_reg <= '0;
            flush_cnt_reg  <= '0;
            aborted_reg    <= 1'b0;
            overflow_reg   <= 1'b0;
            underflow_reg  <= 1'b0;
          end
        end
        FLUSH: begin
          if (stop) begin
            state_reg   <= DONE;
            aborted_reg <= 1'b1;
          end else if (flush_cnt_reg == FCW'(FLUSH_CYCLES - 1)) begin
            state_reg <= (len_reg == '0) ? DONE : RUN;
          end else begin
            flush_cnt_reg <= flush_cnt_reg + 1'b1;
          end
        end
        RUN, DRAIN: begin
          clk_counts_reg <= clk_counts_reg + 64'd1;
          if (fifo_wr_en && !fifo_rd_en) level_reg <= level_reg + 1'b1;
          if (fifo_rd_en && !fifo_wr_en) level_reg <= level_reg - 1'b1;
          if (fifo_wr_en) words_in_reg <= words_in_reg + 32'd1;
          if (fifo_rd_en) words_out_reg <= words_out_reg + 32'd1;
          if (pipe_in_write && in_run && level_full) overflow_reg <= 1'b1;
          if (pipe_out_read && level_empty) underflow_reg <= 1'b1;
          // Stop outranks the natural phase exit taken on the same edge.
          if (stop) begin
            state_reg   <= DONE;
            aborted_reg <= 1'b1;
          end else if (in_run && fifo_wr_en && (words_in_reg + 32'd1 == len_reg)) begin
            state_reg <= DRAIN;
          end else if (!in_run && fifo_rd_en && (words_out_reg + 32'd1 == len_reg)) begin
            state_reg <= DONE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_duplex_transfer_scheduler.sv
// Randomized bench for duplex_transfer_scheduler against a queue-based reference model.
module tb_duplex_transfer_scheduler;

  localparam int DEPTH = 1024;
  localparam int BLOCK = 256;
  localparam int FLUSH_N = 4;
  localparam int LW = $clog2(DEPTH) + 1;

  localparam int P_IDLE = 0, P_FLUSH = 1, P_RUN = 2, P_DRAIN = 3, P_DONE = 4;

  logic          okClk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          clear = 1'b0;
  logic [31:0]   transfer_len = '0;
  logic          pipe_in_write = 1'b0;
  logic          pipe_out_read = 1'b0;
  logic          fifo_wr_en, fifo_rd_en, fifo_flush, pipe_in_ready, pipe_out_ready;
  logic [LW-1:0] level;
  logic [31:0]   words_in, words_out;
  logic [63:0]   clk_counts;
  logic [2:0]    state;
  logic          busy, done, aborted, overflow, underflow;

  duplex_transfer_scheduler #(.DEPTH(DEPTH), .BLOCK_WORDS(BLOCK), .FLUSH_CYCLES(FLUSH_N)) dut (
    .okClk(okClk), .reset_n(reset_n), .start(start), .stop(stop), .clear(clear),
    .transfer_len(transfer_len), .pipe_in_write(pipe_in_write), .pipe_out_read(pipe_out_read),
    .fifo_wr_en(fifo_wr_en), .fifo_rd_en(fifo_rd_en), .fifo_flush(fifo_flush),
    .pipe_in_ready(pipe_in_ready), .pipe_out_ready(pipe_out_ready), .level(level),
    .words_in(words_in), .words_out(words_out), .clk_counts(clk_counts), .state(state),
    .busy(busy), .done(done), .aborted(aborted), .overflow(overflow), .underflow(underflow)
  );

  always #5 okClk = ~okClk;

  // Reference model: phase, latched length, FIFO contents as a queue of word ids.
  int          m_phase;
  longint      m_len, m_in, m_out, m_clk;
  int          m_flush_left;
  bit          m_ovf, m_unf, m_abt;
  int unsigned fifo_q[$];
  int unsigned next_id;

  int vectors = 0;
  int miscompares = 0;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_phase = P_IDLE; m_len = 0; m_in = 0; m_out = 0; m_clk = 0; m_flush_left = 0;
    m_ovf = 0; m_unf = 0; m_abt = 0;
    fifo_q.delete();
  endfunction

  function automatic bit exp_wr(input bit pw);
    return pw && m_phase == P_RUN && fifo_q.size() < DEPTH && m_in < m_len;
  endfunction

  function automatic bit exp_rd(input bit pr);
    return pr && (m_phase == P_RUN || m_phase == P_DRAIN) && fifo_q.size() > 0;
  endfunction

  function automatic void model_step(input bit st, input bit sp, input bit cl,
                                     input logic [31:0] tl, input bit pw, input bit pr,
                                     input bit w, input bit r);
    int lvl;
    lvl = fifo_q.size();
    if (cl) begin
      model_reset();
      return;
    end
    case (m_phase)
      P_IDLE, P_DONE: if (st) begin
        model_reset();
        m_len = longint'(tl);
        m_phase = P_FLUSH;
        m_flush_left = FLUSH_N;
      end
      P_FLUSH: begin
        if (sp) begin
          m_phase = P_DONE; m_abt = 1;
        end else begin
          m_flush_left--;
          if (m_flush_left == 0) m_phase = (m_len == 0) ? P_DONE : P_RUN;
        end
      end
      default: begin
        m_clk++;
        if (pw && m_phase == P_RUN && lvl == DEPTH) m_ovf = 1;
        if (pr && lvl == 0) m_unf = 1;
        if (w) begin fifo_q.push_back(next_id); next_id++; m_in++; end
        if (r) begin void'(fifo_q.pop_front()); m_out++; end
        if (sp) begin
          m_phase = P_DONE; m_abt = 1;
        end else if (m_phase == P_RUN && m_in == m_len) begin
          m_phase = P_DRAIN;
        end else if (m_phase == P_DRAIN && m_out == m_len) begin
          m_phase = P_DONE;
        end
      end
    endcase
  endfunction

  task automatic check_outputs(input string pfx);
    bit     xfer;
    longint rem, need;
    int     lvl;
    lvl  = fifo_q.size();
    xfer = (m_phase == P_RUN || m_phase == P_DRAIN);
    rem  = m_len - m_out;
    need = (rem < BLOCK) ? rem : BLOCK;
    check_value({pfx, ".state"}, 64'(state), 64'(m_phase));
    check_value({pfx, ".level"}, 64'(level), 64'(lvl));
    check_value({pfx, ".words_in"}, 64'(words_in), 64'(m_in));
    check_value({pfx, ".words_out"}, 64'(words_out), 64'(m_out));
    check_value({pfx, ".clk_counts"}, clk_counts, 64'(m_clk));
    check_value({pfx, ".flags"}, {59'd0, busy, done, aborted, overflow, underflow},
                {59'd0, m_phase inside {P_FLUSH, P_RUN, P_DRAIN}, m_phase == P_DONE, m_abt, m_ovf, m_unf});
    check_value({pfx, ".fifo_flush"}, 64'(fifo_flush), 64'(m_phase == P_FLUSH));
    check_value({pfx, ".pipe_in_ready"}, 64'(pipe_in_ready),
                64'(m_phase == P_RUN && DEPTH - lvl >= BLOCK && m_len - m_in >= 1));
    check_value({pfx, ".pipe_out_ready"}, 64'(pipe_out_ready), 64'(xfer && lvl >= need && lvl > 0));
  endtask

  // One clock: drive at the falling edge, check enables mid-cycle, check registers after the edge.
  task automatic cyc(input bit st, input bit sp, input bit cl, input logic [31:0] tl,
                     input bit pw, input bit pr);
    bit w, r;
    @(negedge okClk);
    start = st; stop = sp; clear = cl; transfer_len = tl;
    pipe_in_write = pw; pipe_out_read = pr;
    #1;
    w = exp_wr(pw);
    r = exp_rd(pr);
    check_value("fifo_wr_en", 64'(fifo_wr_en), 64'(w));
    check_value("fifo_rd_en", 64'(fifo_rd_en), 64'(r));
    @(posedge okClk);
    model_step(st, sp, cl, tl, pw, pr, w, r);
    #1;
    check_outputs("cyc");
  endtask

  function automatic bit pick(input int mode);
    return (mode == 2) ? bit'($urandom_range(0, 1)) : bit'(mode == 1);
  endfunction

  // mode: 0 = strobe low, 1 = strobe high, 2 = random
  task automatic drive_until(input int target, input int pw_mode, input int pr_mode, input int budget);
    for (int i = 0; i < budget && m_phase != target; i++)
      cyc(0, 0, 0, 32'd0, pick(pw_mode), pick(pr_mode));
  endtask

  task automatic begin_run(input logic [31:0] len);
    cyc(1, 0, 0, len, 0, 0);
    drive_until(P_RUN, 0, 0, FLUSH_N + 2);
  endtask

  initial begin
    int n;
    logic [31:0] rlen;
    model_reset();
    next_id = 0;

    #23;
    check_outputs("reset");
    @(negedge okClk);
    reset_n = 1'b1;
    cyc(0, 1, 0, 32'd7, 0, 0);
    check_value("stop_in_idle_state", 64'(state), 64'(P_IDLE));

    // Basic run: 512 writes back-to-back, then 512 reads.
    begin_run(32'd512);
    drive_until(P_DRAIN, 1, 0, 600);
    drive_until(P_DONE, 0, 1, 600);
    check_value("basic.done", {words_in, words_out}, {32'd512, 32'd512});
    check_value("basic.clk_counts", clk_counts, 64'd1024);

    // Simultaneous traffic holds level at 1.
    begin_run(32'd1024);
    cyc(0, 0, 0, 32'd0, 1, 0);
    drive_until(P_DONE, 1, 1, 1200);
    check_value("simul.state", 64'(state), 64'(P_DONE));
    check_value("simul.flags", {62'd0, overflow, underflow}, 64'd0);

    // Full FIFO: 1025 writes, no reads; then abort.
    begin_run(32'd2000);
    for (int i = 0; i < 1025; i++) cyc(0, 0, 0, 32'd0, 1, 0);
    check_value("full.level", 64'(level), 64'd1024);
    check_value("full.overflow", 64'(overflow), 64'd1);
    check_value("full.in_ready", 64'(pipe_in_ready), 64'd0);
    cyc(0, 1, 0, 32'd0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 32'd0, 1, 1);
    check_value("full.abort_frozen", 64'(words_in), 64'd1024);

    // Empty read during RUN.
    begin_run(32'd10);
    cyc(0, 0, 0, 32'd0, 0, 1);
    check_value("empty.underflow", 64'(underflow), 64'd1);
    cyc(0, 0, 1, 32'd0, 0, 0);

    // Remainder: 300 words leaves a 44-word tail.
    begin_run(32'd300);
    drive_until(P_DRAIN, 1, 0, 400);
    for (int i = 0; i < 256; i++) cyc(0, 0, 0, 32'd0, 0, 1);
    check_value("remainder.level", 64'(level), 64'd44);
    check_value("remainder.out_ready", 64'(pipe_out_ready), 64'd1);
    drive_until(P_DONE, 0, 1, 100);

    // Abort mid-RUN, then restart with start+stop together in DONE.
    begin_run(32'd100);
    for (int i = 0; i < 50; i++) cyc(0, 0, 0, 32'd0, 1, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 32'd0, 0, pick(2));
    cyc(0, 1, 0, 32'd0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    check_value("abort.state", 64'(state), 64'(P_DONE));
    cyc(1, 1, 0, 32'd20, 0, 0);
    check_value("restart.state", 64'(state), 64'(P_FLUSH));
    drive_until(P_DONE, 2, 2, 500);

    // Clear in RUN.
    begin_run(32'd100);
    for (int i = 0; i < 30; i++) cyc(0, 0, 0, 32'd0, 1, pick(2));
    cyc(1, 1, 1, 32'd5, 0, 0);
    check_value("clear.state", 64'(state), 64'(P_IDLE));

    // Randomized runs with stray start pulses while busy.
    for (int k = 0; k < 6; k++) begin
      rlen = $urandom_range(1, 400);
      begin_run(rlen);
      n = 0;
      while (m_phase != P_DONE && n < 5000) begin
        cyc(bit'($urandom_range(0, 30) == 0), 0, 0, $urandom, pick(2), pick(2));
        n++;
      end
      check_value("random.done", 64'(state), 64'(P_DONE));
    end

    // Asynchronous reset in DRAIN, between edges.
    begin_run(32'd40);
    drive_until(P_DRAIN, 1, 0, 60);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 32'd0, 0, 1);
    @(negedge okClk);
    pipe_out_read = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_reset");
    check_value("async_reset.enables", {62'd0, fifo_wr_en, fifo_rd_en}, 64'd0);
    @(negedge okClk);
    reset_n = 1'b1;

    // Zero-length run: four flush cycles straight to DONE.
    cyc(1, 0, 0, 32'd0, 0, 0);
    n = 0;
    for (int i = 0; i < 10 && m_phase != P_DONE; i++) begin
      if (fifo_flush === 1'b1) n++;
      cyc(0, 0, 0, 32'd0, 1, 1);
    end
    check_value("len0.flush_cycles", 64'(n), 64'(FLUSH_N));
    check_value("len0.clk_counts", clk_counts, 64'd0);
    check_value("len0.state", 64'(state), 64'(P_DONE));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/duplex_transfer_scheduler.md
# duplex_transfer_scheduler

Sequencing and flow-control controller for the bidirectional duplex FIFO loopback test. It sits between the okPipeIn/okPipeOut endpoints and the 32-bit FIFO. It gates the pipe strobes into FIFO write/read enables, tracks occupancy, and throttles block-transfer pipes through ready flags. It also runs a flush → run → drain test sequence and reports cycle and word counts to wire-outs.

## Interface
Parameters:
- DEPTH, 1024, FIFO capacity in words
- BLOCK_WORDS, 256, pipe block size used for ready flags
- FLUSH_CYCLES, 4, cycles fifo_flush is held at test start

Ports:
- okClk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle trigger: begin a test run
- stop  in  1  single-cycle trigger: abort the run
- clear  in  1  synchronous clear: return to IDLE, zero all counters and flags
- transfer_len  in  32  words to move in each direction; sampled on start
- pipe_in_write  in  1  okPipeIn ep_write strobe
- pipe_out_read  in  1  okPipeOut ep_read strobe
- fifo_wr_en  out  1  FIFO write enable
- fifo_rd_en  out  1  FIFO read enable
- fifo_flush  out  1  FIFO synchronous reset
- pipe_in_ready  out  1  space for one full block
- pipe_out_ready  out  1  one block, or the final remainder, available
- level  out  $clog2(DEPTH)+1  FIFO occupancy
- words_in, words_out  out  32 each  accepted write / read counts
- clk_counts  out  64  cycles spent in RUN+DRAIN
- state  out  3  IDLE=0, FLUSH=1, RUN=2, DRAIN=3, DONE=4
- busy, done, aborted, overflow, underflow  out  1 each  status bits

## Operation
- Reset (async, reset_n=0) state: all outputs 0, state=IDLE, and the latched length is 0.
- IDLE/DONE + start:
  - latch transfer_len;
  - zero level, words_in, words_out, clk_counts and all flags;
  - go to FLUSH.
- While busy (FLUSH/RUN/DRAIN), start is ignored.
- FLUSH:
  - fifo_flush=1 for exactly FLUSH_CYCLES cycles;
  - then go to RUN, or to DONE directly if the latched length is 0.
- RUN:
  - fifo_wr_en = pipe_in_write & (level<DEPTH) & (words_in<len).
  - A pipe_in_write with level==DEPTH sets sticky overflow; the word is dropped.
  - A pipe_in_write with words_in==len is ignored and sets no flag.
  - fifo_rd_en = pipe_out_read & (level>0), in both RUN and DRAIN.
  - A pipe_out_read with level==0 sets sticky underflow; the output word is invalid.
  - Go to DRAIN on the cycle words_in becomes len.
- DRAIN: writes are gated off. Go to DONE on the cycle words_out becomes len.
- Level update: +1 on a write only, -1 on a read only, unchanged when both occur in the same cycle. Level never leaves 0..DEPTH.
- Counters are 32-bit (64-bit for clk_counts) and wrap silently.
- pipe_in_ready = (state==RUN) & (DEPTH-level ≥ BLOCK_WORDS) & (len-words_in ≥ 1).
- pipe_out_ready = (state∈{RUN,DRAIN}) & (level ≥ min(BLOCK_WORDS, len-words_out)) & (level>0).
- stop in FLUSH/RUN/DRAIN:
  - go to DONE with aborted=1;
  - counters freeze;
  - fifo_flush is not asserted.
- stop in IDLE/DONE is ignored.
- start and stop in the same cycle: stop wins if busy; start wins in IDLE/DONE.
- clear has priority over start and stop, in any state: go to IDLE with everything zeroed.
- busy=1 in FLUSH/RUN/DRAIN. done=1 in DONE.

## Timing
- fifo_wr_en and fifo_rd_en are combinational from the strobes and registered state/level, so the FIFO sees the enable in the same cycle as the pipe data/strobe. No other combinational input-to-output paths exist.
- All other outputs are registered and reflect an event one cycle after it.
- start at edge t: state=FLUSH and fifo_flush=1 on cycles t+1..t+FLUSH_CYCLES, then state=RUN on cycle t+FLUSH_CYCLES+1.
- clk_counts increments on every cycle whose registered state is RUN or DRAIN.
- The final read moves the block to DONE on the next cycle; clk_counts stops there.
- Ready flags update one cycle after the level changes. Block pipes sample them only at block boundaries, so one-cycle staleness is safe.

## Test plan
- Basic run:
  - Stimulus: len=512; write 512 words back-to-back, then read 512.
  - Required: words_in=words_out=512, level=0, done=1; clk_counts equals the cycles spent in RUN+DRAIN; no flags set.
- Simultaneous traffic:
  - Stimulus: len=1024; assert write and read together on every cycle once level ≥ 1.
  - Required: level holds constant; DONE is reached; overflow=underflow=0.
- Full FIFO:
  - Stimulus: len=2000; write 1025 words with no reads.
  - Required: level=1024, words_in=1024, overflow=1; pipe_in_ready=0 from level 769 onward.
- Empty FIFO / remainder:
  - Stimulus: read with level=0 during RUN.
  - Required: fifo_rd_en=0, underflow=1.
  - Stimulus: len=300 with 300 words written.
  - Required: pipe_out_ready=1 while words_out ≥ 256 and level=44.
- Abort and clear:
  - Stimulus: stop mid-RUN.
  - Required: state=DONE, aborted=1, counters frozen; a later start restarts from FLUSH with zeroed counters.
  - Stimulus: clear in RUN.
  - Required: state=IDLE, all zero.
- Reset mid-operation:
  - Stimulus: drop reset_n asynchronously in DRAIN, between clock edges.
  - Required: all outputs go to 0 immediately, state=IDLE.
  - Stimulus: len=0 start.
  - Required: FLUSH for 4 cycles, then DONE, with clk_counts=0.
